// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the 3-bit sequence generator/detector pair:
// pattern symbols, idle symbol and generator state encodings.
package sequence_generator_pkg;

   localparam logic [2:0] P0 = 3'b001;
   localparam logic [2:0] P1 = 3'b101;
   localparam logic [2:0] P2 = 3'b110;
   localparam logic [2:0] P3 = 3'b000;
   localparam logic [2:0] P4 = 3'b110;
   localparam logic [2:0] P5 = 3'b110;
   localparam logic [2:0] P6 = 3'b011;
   localparam logic [2:0] P7 = 3'b101;

   localparam logic [2:0] IDLE_SYM    = 3'b111;
   localparam int         PATTERN_LEN = 8;

   localparam logic [1:0] GEN_IDLE_ENC = 2'd0;
   localparam logic [1:0] GEN_SEND_ENC = 2'd1;
   localparam logic [1:0] GEN_DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = GEN_IDLE_ENC,
      ST_SEND = GEN_SEND_ENC,
      ST_DONE = GEN_DONE_ENC
   } gen_state_e;

endpackage

// File: rtl/sequence_symbol_rom.sv
// Combinational lookup from pattern position (0..7) to the 3-bit symbol.
module sequence_symbol_rom
   import sequence_generator_pkg::*;
(
   input  logic [2:0] idx,
   output logic [2:0] sym
);

   always_comb begin
      sym = IDLE_SYM;
      case (idx)
         3'd0: sym = P0;
         3'd1: sym = P1;
         3'd2: sym = P2;
         3'd3: sym = P3;
         3'd4: sym = P4;
         3'd5: sym = P5;
         3'd6: sym = P6;
         3'd7: sym = P7;
         default: sym = IDLE_SYM;
      endcase
   end

endmodule

// File: rtl/sequence_generator.sv
// Emits the 8-symbol pattern repeat_count+1 times over a valid/ready bus.
// All outputs are registered; abort wins over start and over a handshake.
module sequence_generator
   import sequence_generator_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] repeat_count,
   input  logic       abort,
   input  logic       data_ready,
   output logic [2:0] data,
   output logic       data_valid,
   output logic       busy,
   output logic       done
);

   gen_state_e state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] frames_left_q, frames_left_d;
   logic [2:0] data_q, data_d;
   logic       data_valid_q, data_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [2:0] rom_addr;
   logic [2:0] rom_sym;
   logic       beat;

   // The next symbol is always at idx+1; the 3-bit wrap from 7 lands on P0.
   assign rom_addr = idx_q + 3'd1;
   assign beat     = data_valid_q & data_ready;

   sequence_symbol_rom u_rom (
      .idx (rom_addr),
      .sym (rom_sym)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= 3'd0;
         frames_left_q <= 4'd0;
         data_q        <= IDLE_SYM;
         data_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         frames_left_q <= frames_left_d;
         data_q        <= data_d;
         data_valid_q  <= data_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      frames_left_d = frames_left_q;
      data_d        = data_q;
      data_valid_d  = data_valid_q;
      busy_d        = busy_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!abort && start) begin
               state_d       = ST_SEND;
               idx_d         = 3'd0;
               frames_left_d = repeat_count;
               data_d        = P0;
               data_valid_d  = 1'b1;
               busy_d        = 1'b1;
            end
         end

         ST_SEND: begin
            if (abort) begin
               state_d       = ST_IDLE;
               idx_d         = 3'd0;
               frames_left_d = 4'd0;
               data_d        = IDLE_SYM;
               data_valid_d  = 1'b0;
               busy_d        = 1'b0;
            end else if (beat) begin
               if (idx_q != 3'd7) begin
                  idx_d  = idx_q + 3'd1;
                  data_d = rom_sym;
               end else if (frames_left_q != 4'd0) begin
                  idx_d         = 3'd0;
                  frames_left_d = frames_left_q - 4'd1;
                  data_d        = rom_sym;
               end else begin
                  state_d      = ST_DONE;
                  idx_d        = 3'd0;
                  data_d       = IDLE_SYM;
                  data_valid_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d       = ST_IDLE;
            idx_d         = 3'd0;
            frames_left_d = 4'd0;
            data_d        = IDLE_SYM;
            data_valid_d  = 1'b0;
            busy_d        = 1'b0;
         end
      endcase
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: directed scenarios plus random traffic compared
// every cycle against a beat-counting reference model.
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] repeat_count;
   logic       abort;
   logic       data_ready;
   logic [2:0] data;
   logic       data_valid;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   logic [2:0] pat [8] = '{3'b001, 3'b101, 3'b110, 3'b000,
                           3'b110, 3'b110, 3'b011, 3'b101};

   // Model: 0 idle, 1 sending, 2 done; a burst is just a count of beats.
   int m_phase;
   int m_beats_left;
   int m_pos;

   int beat_cnt;
   int done_cnt;

   sequence_generator dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .repeat_count (repeat_count),
      .abort        (abort),
      .data_ready   (data_ready),
      .data         (data),
      .data_valid   (data_valid),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAll(input string tag);
      logic       e_valid;
      logic [2:0] e_data;
      e_valid = (m_phase == 1);
      e_data  = e_valid ? pat[m_pos % 8] : 3'b111;
      checkOutput({tag, "_valid"}, int'(data_valid), int'(e_valid));
      checkOutput({tag, "_data"},  int'(data),       int'(e_data));
      checkOutput({tag, "_busy"},  int'(busy),       int'(e_valid));
      checkOutput({tag, "_done"},  int'(done),       int'(m_phase == 2));
   endtask

   task automatic modelReset();
      m_phase      = 0;
      m_beats_left = 0;
      m_pos        = 0;
   endtask

   // One clock: drive inputs, advance the model at the edge, check after it.
   task automatic applyStimulus(input logic s, input logic [3:0] rc,
                                input logic ab, input logic rdy);
      start        = s;
      repeat_count = rc;
      abort        = ab;
      data_ready   = rdy;
      #1;
      if (data_valid && data_ready) beat_cnt++;
      @(posedge clk);
      case (m_phase)
         0: if (!ab && s) begin
               m_phase      = 1;
               m_beats_left = (int'(rc) + 1) * 8;
               m_pos        = 0;
            end
         1: if (ab) begin
               m_phase = 0;
            end else if (rdy) begin
               m_beats_left--;
               m_pos++;
               if (m_beats_left == 0) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
      #1;
      if (done) done_cnt++;
      checkAll("cyc");
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic clearCounts();
      beat_cnt = 0;
      done_cnt = 0;
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      repeat_count = 4'd0;
      abort        = 1'b0;
      data_ready   = 1'b0;
      modelReset();
      clearCounts();
      #1;
      checkAll("rst_async");
      @(posedge clk);
      #1;
      checkAll("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      idleCycles(2);

      $display("[TB] single frame");
      clearCounts();
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      idleCycles(10);
      checkOutput("single_beats", beat_cnt, 8);
      checkOutput("single_done", done_cnt, 1);

      $display("[TB] repeat x3");
      clearCounts();
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
      idleCycles(27);
      checkOutput("rep_beats", beat_cnt, 24);
      checkOutput("rep_done", done_cnt, 1);

      $display("[TB] backpressure");
      clearCounts();
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("bp_sym_at_stall", int'(data), 6);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      checkOutput("bp_sym_held", int'(data), 6);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
      checkOutput("bp_sym_after", int'(data), 0);
      idleCycles(8);
      checkOutput("bp_beats", beat_cnt, 8);
      checkOutput("bp_done", done_cnt, 1);

      $display("[TB] start while busy");
      clearCounts();
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      idleCycles(3);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
      idleCycles(10);
      checkOutput("busy_start_beats", beat_cnt, 8);
      checkOutput("busy_start_done", done_cnt, 1);

      $display("[TB] abort");
      clearCounts();
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      idleCycles(4);
      applyStimulus(1'b1, 4'd0, 1'b1, 1'b1);
      idleCycles(3);
      checkOutput("abort_done", done_cnt, 0);
      clearCounts();
      applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      checkOutput("abort_restart_p0", int'(data), 1);
      idleCycles(10);
      checkOutput("abort_restart_beats", beat_cnt, 8);

      $display("[TB] async reset mid burst");
      applyStimulus(1'b1, 4'd2, 1'b0, 1'b1);
      idleCycles(11);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkAll("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      clearCounts();
      idleCycles(5);
      checkOutput("rst_quiet_beats", beat_cnt, 0);

      $display("[TB] random traffic");
      clearCounts();
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(5) == 0),
                       4'($urandom_range(3)),
                       ($urandom_range(39) == 0),
                       ($urandom_range(3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
